sort_fifo: RTL and testbench



---
 rtl/sort_pkg.sv | 9 +
 rtl/sort_fifo_ptr.sv | 35 +++
 rtl/sort_fifo.sv | 101 ++++++++++
 tb/tb_sort_fifo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared sorter constants: key width and default FIFO depth used by the input
// buffer, the sort FIFO and the merge stages.
package sort_pkg;

  localparam int unsigned KEY_W             = 32;
  localparam int unsigned FIFO_DEPTH        = 16;
  localparam int unsigned FIFO_AFULL_MARGIN = 2;

endpackage : sort_pkg

// File: rtl/sort_fifo_ptr.sv
// One FIFO pointer with a wrap bit above the index bits, an increment enable
// and a synchronous active-low reset.
module sort_fifo_ptr #(
  parameter int unsigned AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [AW:0] ptr_o
);

  logic [AW:0] ptr_q;
  logic [AW:0] ptr_d;

  // next pointer value: advance by one when enabled, wrapping naturally
  always_comb begin
    if (inc_i) begin
      ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : sort_fifo_ptr

// File: rtl/sort_fifo.sv
// First-word-fall-through key FIFO between the sorter input buffer and the
// first merge stage, with occupancy and sticky overflow/underflow flags.
module sort_fifo
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH        = KEY_W,
  parameter int unsigned DEPTH        = FIFO_DEPTH,
  parameter int unsigned AFULL_MARGIN = FIFO_AFULL_MARGIN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         din,
  input  logic                     enq,
  input  logic                     deq,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     afull,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     ovf,
  output logic                     udf
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_TH = (AW+1)'(DEPTH - AFULL_MARGIN);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_ptr_s;
  logic [AW:0]      rp_ptr_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             ovf_q;
  logic             ovf_d;
  logic             udf_q;
  logic             udf_d;

  // Equal index bits with differing wrap bits distinguishes full from empty.
  assign full_s  = (wp_ptr_s[AW-1:0] == rp_ptr_s[AW-1:0]) && (wp_ptr_s[AW] != rp_ptr_s[AW]);
  assign empty_s = (wp_ptr_s == rp_ptr_s);
  assign push_s  = rst_n && enq && !full_s;
  assign pop_s   = rst_n && deq && !empty_s;

  sort_fifo_ptr #(.AW(AW)) wp (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (push_s),
    .ptr_o (wp_ptr_s)
  );

  sort_fifo_ptr #(.AW(AW)) rp (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pop_s),
    .ptr_o (rp_ptr_s)
  );

  // key storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wp_ptr_s[AW-1:0]] <= din;
    end
  end

  // sticky error flags: enq while full, deq while empty
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (enq && full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (deq && empty_s) begin
      udf_d = 1'b1;
    end else begin
      udf_d = udf_q;
    end
  end

  // sticky flag registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign cnt   = wp_ptr_s - rp_ptr_s;
  assign full  = full_s;
  assign empty = empty_s;
  assign afull = (cnt >= AFULL_TH);
  assign ovf   = ovf_q;
  assign udf   = udf_q;
  assign dout  = empty_s ? {WIDTH{1'b0}} : mem_q[rp_ptr_s[AW-1:0]];

endmodule : sort_fifo

// File: tb/tb_sort_fifo.sv
// Randomised scoreboard bench for sort_fifo against a queue-based FIFO model.
module tb_sort_fifo;

  localparam int DEPTH = 16;
  localparam int MARGIN = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        enq;
  logic        deq;
  logic [31:0] dout;
  logic        full;
  logic        afull;
  logic        empty;
  logic [4:0]  cnt;
  logic        ovf;
  logic        udf;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];     // model contents, oldest first
  logic [31:0] exp_q[$];  // scoreboard: keys expected to be popped this cycle
  bit          m_ovf;
  bit          m_udf;

  sort_fifo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .enq   (enq),
    .deq   (deq),
    .dout  (dout),
    .full  (full),
    .afull (afull),
    .empty (empty),
    .cnt   (cnt),
    .ovf   (ovf),
    .udf   (udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = mq.size();
    chk("cnt",   32'(cnt),   32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full",  32'(full),  32'(n == DEPTH));
    chk("afull", 32'(afull), 32'(n >= DEPTH - MARGIN));
    chk("ovf",   32'(ovf),   32'(m_ovf));
    chk("udf",   32'(udf),   32'(m_udf));
    chk("dout",  dout,       (n == 0) ? 32'd0 : mq[0]);
  endtask

  // Drive one cycle of requests, predict its effect, then check status after the edge.
  task automatic step(input logic en, input logic de, input logic [31:0] d);
    bit was_full;
    bit was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    enq = en;
    deq = de;
    din = d;
    if (de && !was_empty) exp_q.push_back(mq.pop_front());
    else if (de) m_udf = 1'b1;
    if (en && !was_full) mq.push_back(d);
    else if (en) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic do_reset(input int n, input logic en);
    rst_n = 1'b0;
    enq   = en;
    deq   = 1'b0;
    din   = 32'd1234;
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check_status();
    end
    rst_n = 1'b1;
    enq   = 1'b0;
  endtask

  // Monitor: each accepted pop must present the oldest outstanding key.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && deq && !empty) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got %0d expected none at %0t", dout, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", dout, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    enq   = 1'b0;
    deq   = 1'b0;
    din   = 32'd0;
    m_ovf = 1'b0;
    m_udf = 1'b0;

    do_reset(2, 1'b1);

    step(1'b1, 1'b0, 32'd32651);
    step(1'b1, 1'b0, 32'd65432);
    step(1'b1, 1'b0, 32'd4532);
    repeat (3) step(1'b0, 1'b1, 32'd0);

    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 32'(i));
    step(1'b1, 1'b0, 32'd99);
    repeat (16) step(1'b0, 1'b1, 32'd0);

    do_reset(1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(100 + i));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 32'd32651 : 32'd65432);
    repeat (5) step(1'b0, 1'b1, 32'd0);

    step(1'b1, 1'b1, 32'd7);
    step(1'b0, 1'b1, 32'd0);

    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, $urandom);
    do_reset(1, 1'b1);
    step(1'b1, 1'b0, 32'd5);
    step(1'b0, 1'b1, 32'd0);

    do_reset(1, 1'b0);
    for (int ph = 0; ph < 6; ph++) begin
      int pe;
      int pd;
      pe = (ph % 2 == 0) ? 75 : 30;
      pd = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 80; i++) begin
        step(1'($urandom_range(0, 99) < pe), 1'($urandom_range(0, 99) < pd), $urandom);
      end
    end
    while (mq.size() > 0) step(1'b0, 1'b1, 32'd0);

    step(1'b0, 1'b0, 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sort_fifo
